txn_done_flag: RTL and testbench



---
 rtl/txn_done_flag.sv | 41 ++++
 tb/tb_txn_done_flag.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/txn_done_flag.sv
// Sticky completion flag for one valid/ready channel; done rises with the handshake (same cycle when bypassed, else next edge).
// Passive observer: never drives valid/ready, so it adds no backpressure to the monitored channel.
module txn_done_flag #(
  parameter bit COMB_BYPASS = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic ready,
  input  logic clear,
  output logic done
);

  logic w_hs;
  logic w_live;
  logic r_done_ff;

  assign w_hs = valid & ready;

  // clear outranks a coincident handshake so the consumer never sees a stale set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_ff <= 1'b0;
    end else if (clear) begin
      r_done_ff <= 1'b0;
    end else if (w_hs) begin
      r_done_ff <= 1'b1;
    end
  end

  generate
    if (COMB_BYPASS) begin : g_bypass
      assign w_live = w_hs;
    end else begin : g_reg_only
      assign w_live = 1'b0;
    end
  endgenerate

  assign done = r_done_ff | w_live;

endmodule

// File: tb/tb_txn_done_flag.sv
// Scoreboard bench driving two builds (bypass on/off) with shared stimulus.
module tb_txn_done_flag;

  logic clk;
  logic reset;
  logic valid;
  logic ready;
  logic clear;
  logic done_byp;
  logic done_reg;

  int tests_run;
  int tests_failed;

  // Model state: edge stamps of the latest flag-setting and flag-clearing events.
  int edge_n;
  int last_hs;
  int last_clr;
  logic p_valid, p_ready, p_clear, p_reset;

  logic exp_byp_q[$];
  logic exp_reg_q[$];

  txn_done_flag #(.COMB_BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .clear(clear), .done(done_byp)
  );

  txn_done_flag #(.COMB_BYPASS(1'b0)) u_reg (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .clear(clear), .done(done_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag is set iff some handshake edge happened strictly after the last clear/reset point.
  task automatic cyc(input logic v, input logic r, input logic c, input logic rst);
    logic flag;
    @(posedge clk);
    edge_n++;
    if (p_valid && p_ready) last_hs = edge_n;
    if (!p_reset || p_clear) last_clr = edge_n;
    #1;
    valid = v;
    ready = r;
    clear = c;
    reset = rst;
    if (!rst) last_clr = edge_n;
    flag = (last_hs > last_clr);
    exp_byp_q.push_back(flag | (v & r));
    exp_reg_q.push_back(flag);
    p_valid = v;
    p_ready = r;
    p_clear = c;
    p_reset = rst;
  endtask

  always @(negedge clk) begin
    logic eb;
    logic er;
    if (exp_byp_q.size() > 0 && exp_reg_q.size() > 0) begin
      eb = exp_byp_q.pop_front();
      er = exp_reg_q.pop_front();
      tests_run++;
      if (done_byp !== eb) begin
        tests_failed++;
        $display("FAIL done_bypass t=%0t got=%b want=%b", $time, done_byp, eb);
      end
      tests_run++;
      if (done_reg !== er) begin
        tests_failed++;
        $display("FAIL done_registered t=%0t got=%b want=%b", $time, done_reg, er);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edge_n   = 0;
    last_hs  = -1;
    last_clr = 0;
    reset = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    clear = 1'b0;
    p_reset = 1'b0;
    p_valid = 1'b0;
    p_ready = 1'b0;
    p_clear = 1'b0;

    // reset then idle
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // basic handshake and persistence
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // clear
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // reset held with live handshake
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    // partial handshakes
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    // clear and handshake on the same edge
    cyc(1, 1, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // continuous handshake, then re-set after reset release
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 15) != 0));
    end
    cyc(0, 0, 0, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_byp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_byp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
